// File: rtl/race_controller_if.sv
// race_controller_if: button/frame/collision inputs and HUD/datapath outputs of the game sequencer
interface race_controller_if;
  logic        start_btn;
  logic        frame_tick;
  logic        collision;
  logic        reset_game;
  logic        move_en;
  logic [2:0]  game_state;
  logic [1:0]  countdown;
  logic [2:0]  speed_level;
  logic [13:0] score;
  logic [1:0]  lives;
  modport master (
    output start_btn, frame_tick, collision,
    input  reset_game, move_en, game_state, countdown, speed_level, score, lives
  );
  modport slave (
    input  start_btn, frame_tick, collision,
    output reset_game, move_en, game_state, countdown, speed_level, score, lives
  );
endinterface

// File: rtl/race_controller.sv
// race_controller: game state machine driving restart, countdown, motion gating, score, level and lives
module race_controller #(
  parameter int unsigned COUNTDOWN_FRAMES = 60,
  parameter int unsigned CRASH_FRAMES     = 120,
  parameter int unsigned LEVEL_UP_FRAMES  = 600,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned LIVES_INIT       = 3,
  parameter int unsigned SCORE_MAX        = 9999
) (
  input logic              iVGA_CLK,
  input logic              iRST,
  race_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RESTART, COUNTDOWN, RUN, CRASH, OVER} state_t;
  state_t      r_state;
  logic [9:0]  r_cnt;
  logic        r_start_d;
  logic        r_rise;
  logic        r_new_game;
  logic        r_reset_game;
  logic        r_move_en;
  logic [1:0]  r_countdown;
  logic [1:0]  r_lives;
  logic [2:0]  r_level;
  logic [13:0] r_score;
  logic [14:0] w_sum;
  assign w_sum = {1'b0, r_score} + 15'(r_level) + 15'd1;
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_start_d    <= 1'b0;
      r_rise       <= 1'b0;
      r_new_game   <= 1'b0;
      r_reset_game <= 1'b0;
      r_move_en    <= 1'b0;
      r_countdown  <= '0;
      r_lives      <= 2'(LIVES_INIT);
      r_level      <= '0;
      r_score      <= '0;
    end else begin
      r_start_d    <= bus.start_btn;
      r_rise       <= bus.start_btn & ~r_start_d;
      r_reset_game <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (r_rise) begin
            r_state      <= RESTART;
            r_new_game   <= 1'b1;
            r_reset_game <= 1'b1;
          end
        end
        RESTART: begin
          if (r_new_game) begin
            r_score <= '0;
            r_level <= '0;
            r_lives <= 2'(LIVES_INIT);
          end
          r_new_game  <= 1'b0;
          r_state     <= COUNTDOWN;
          r_countdown <= 2'd3;
          r_cnt       <= '0;
        end
        COUNTDOWN: begin
          if (bus.frame_tick) begin
            if (r_cnt == 10'(COUNTDOWN_FRAMES - 1)) begin
              r_cnt <= '0;
              if (r_countdown == 2'd1) begin
                r_state     <= RUN;
                r_countdown <= '0;
                r_move_en   <= 1'b1;
              end else begin
                r_countdown <= r_countdown - 2'd1;
              end
            end else begin
              r_cnt <= r_cnt + 10'd1;
            end
          end
        end
        RUN: begin
          if (bus.collision) begin
            r_lives   <= r_lives - 2'd1;
            r_move_en <= 1'b0;
            r_cnt     <= '0;
            r_state   <= (r_lives == 2'd1) ? OVER : CRASH;
          end else if (bus.frame_tick) begin
            r_score <= (w_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_sum[13:0];
            if (r_cnt == 10'(LEVEL_UP_FRAMES - 1)) begin
              r_cnt   <= '0;
              r_level <= (r_level == 3'(MAX_LEVEL)) ? r_level : r_level + 3'd1;
            end else begin
              r_cnt <= r_cnt + 10'd1;
            end
          end
        end
        CRASH: begin
          if (bus.frame_tick) begin
            if (r_cnt == 10'(CRASH_FRAMES - 1)) begin
              r_cnt        <= '0;
              r_state      <= RESTART;
              r_new_game   <= 1'b0;
              r_reset_game <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 10'd1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_move_en   <= 1'b0;
          r_countdown <= '0;
        end
      endcase
    end
  end
  assign bus.game_state  = r_state;
  assign bus.reset_game  = r_reset_game;
  assign bus.move_en     = r_move_en;
  assign bus.countdown   = r_countdown;
  assign bus.speed_level = r_level;
  assign bus.score       = r_score;
  assign bus.lives       = r_lives;
endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: directed vector table plus hand-written game sequences for race_controller
module tb_race_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  race_controller_if bus();
  race_controller dut (.iVGA_CLK(clk), .iRST(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic st;
    logic ft;
    logic col;
    int   state;
    int   rg;
    int   me;
    int   cd;
    int   lives;
  } vec_t;
  vec_t v[8];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic st, input logic ft, input logic col);
    bus.start_btn  = st;
    bus.frame_tick = ft;
    bus.collision  = col;
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(bus.start_btn, 1'b1, 1'b0);
    bus.frame_tick = 1'b0;
  endtask
  task automatic snap(input string nm, input int st, input int rg, input int me, input int cd, input int lv, input int sc, input int lvl);
    chk({nm, ".state"}, int'(bus.game_state), st);
    chk({nm, ".reset_game"}, int'(bus.reset_game), rg);
    chk({nm, ".move_en"}, int'(bus.move_en), me);
    chk({nm, ".countdown"}, int'(bus.countdown), cd);
    chk({nm, ".lives"}, int'(bus.lives), lv);
    chk({nm, ".score"}, int'(bus.score), sc);
    chk({nm, ".level"}, int'(bus.speed_level), lvl);
  endtask
  initial begin
    v[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 3};
    v[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 3};
    v[2] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 3};
    v[3] = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 3, 3};
    v[4] = '{1'b1, 1'b0, 1'b1, 2, 0, 0, 3, 3};
    v[5] = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 3, 3};
    v[6] = '{1'b0, 1'b0, 1'b1, 2, 0, 0, 3, 3};
    v[7] = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 3, 3};
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    snap("reset", 0, 0, 0, 0, 3, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(v[i].st, v[i].ft, v[i].col);
      chk($sformatf("vec%0d.state", i), int'(bus.game_state), v[i].state);
      chk($sformatf("vec%0d.reset_game", i), int'(bus.reset_game), v[i].rg);
      chk($sformatf("vec%0d.move_en", i), int'(bus.move_en), v[i].me);
      chk($sformatf("vec%0d.countdown", i), int'(bus.countdown), v[i].cd);
      chk($sformatf("vec%0d.lives", i), int'(bus.lives), v[i].lives);
    end
    ticks(59);
    snap("cd2", 2, 0, 0, 2, 3, 0, 0);
    ticks(60);
    snap("cd1", 2, 0, 0, 1, 3, 0, 0);
    ticks(59);
    snap("cd1_end", 2, 0, 0, 1, 3, 0, 0);
    ticks(1);
    snap("run", 3, 0, 1, 0, 3, 0, 0);
    ticks(600);
    snap("lvl_up", 3, 0, 1, 0, 3, 600, 1);
    ticks(1);
    snap("add2", 3, 0, 1, 0, 3, 602, 1);
    cyc(1'b0, 1'b1, 1'b1);
    snap("crash", 4, 0, 0, 0, 2, 602, 1);
    ticks(119);
    snap("crash_hold", 4, 0, 0, 0, 2, 602, 1);
    ticks(1);
    snap("restart", 1, 1, 0, 0, 2, 602, 1);
    cyc(1'b0, 1'b0, 1'b0);
    snap("retain", 2, 0, 0, 3, 2, 602, 1);
    ticks(180);
    snap("run2", 3, 0, 1, 0, 2, 602, 1);
    ticks(600);
    snap("lvl2", 3, 0, 1, 0, 2, 1802, 2);
    ticks(3000);
    snap("sat", 3, 0, 1, 0, 2, 9999, 7);
    ticks(600);
    snap("sat_hold", 3, 0, 1, 0, 2, 9999, 7);
    cyc(1'b0, 1'b0, 1'b1);
    snap("crash2", 4, 0, 0, 0, 1, 9999, 7);
    ticks(120);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(180);
    snap("run3", 3, 0, 1, 0, 1, 9999, 7);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    snap("start_in_run", 3, 0, 1, 0, 1, 9999, 7);
    cyc(1'b1, 1'b0, 1'b1);
    snap("over", 5, 0, 0, 0, 0, 9999, 7);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    snap("over_held", 5, 0, 0, 0, 0, 9999, 7);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    snap("over_press", 5, 0, 0, 0, 0, 9999, 7);
    cyc(1'b1, 1'b0, 1'b0);
    snap("new_restart", 1, 1, 0, 0, 0, 9999, 7);
    cyc(1'b0, 1'b0, 1'b0);
    snap("new_game", 2, 0, 0, 3, 3, 0, 0);
    ticks(70);
    snap("mid_cd", 2, 0, 0, 2, 3, 0, 0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    snap("rst_cd", 0, 0, 0, 0, 3, 0, 0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    snap("cd_again", 2, 0, 0, 3, 3, 0, 0);
    ticks(180);
    cyc(1'b0, 1'b0, 1'b1);
    snap("crash3", 4, 0, 0, 0, 2, 0, 0);
    ticks(5);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    snap("rst_crash", 0, 0, 0, 0, 3, 0, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    snap("idle_after", 0, 0, 0, 0, 3, 0, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
